// File: rtl/m_port_ultra_point_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : m_port_ultra_pkg
// Brief  : Shared quickhull constants, point type and loader state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package m_port_ultra_pkg;

    localparam int PTSIZE = 16;
    localparam int LNSIZE = 32;
    localparam int MAXPTS = 256;
    localparam int BUSW   = PTSIZE * MAXPTS;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } point_t;

    typedef enum logic [1:0] {
        LD_FILL  = 2'd0,
        LD_DRAIN = 2'd1,
        LD_HOLD  = 2'd2
    } loader_state_e;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/m_port_ultra_point_loader_if.sv
`default_nettype none
// ============================================================================
// Module : m_port_ultra_point_loader_if
// Brief  : Point stream in, packed point set out, with set acknowledge.
// Rev    : 1.0  initial release
// ============================================================================
interface m_port_ultra_point_loader_if;
    import m_port_ultra_pkg::*;

    logic [PTSIZE-1:0] in_point;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [BUSW-1:0]   points;
    logic [7:0]        set_size;
    logic              set_valid;
    logic              set_ack;
    logic              trunc_err;

    modport master (
        output in_point, in_valid, in_last, set_ack,
        input  in_ready, points, set_size, set_valid, trunc_err
    );

    modport slave (
        input  in_point, in_valid, in_last, set_ack,
        output in_ready, points, set_size, set_valid, trunc_err
    );

endinterface
`default_nettype wire

// File: rtl/m_port_ultra_point_loader.sv
`default_nettype none
// ============================================================================
// Module : m_port_ultra_point_loader
// Brief  : Packs a 16-bit point stream into a 4096-bit set held until acked.
// Rev    : 1.0  initial release
// ============================================================================
module m_port_ultra_point_loader
    import m_port_ultra_pkg::*;
(
    input  wire logic                  CLK100MHZ,
    input  wire logic                  CPU_RESETN,
    m_port_ultra_point_loader_if.slave bus
);

    logic [1:0]      state;
    logic [7:0]      idx;
    logic [BUSW-1:0] points_q;
    logic [7:0]      size_q;
    logic            trunc_q;
    logic            ready;
    logic            transfer;

    assign ready    = (state != ST_HOLD);
    assign transfer = bus.in_valid & ready;

    assign bus.in_ready  = ready;
    assign bus.set_valid = (state == ST_HOLD);
    assign bus.points    = points_q;
    assign bus.set_size  = size_q;
    assign bus.trunc_err = trunc_q;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state    <= ST_FILL;
            idx      <= 8'd0;
            points_q <= '0;
            size_q   <= 8'd0;
            trunc_q  <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (transfer) begin
                        points_q[int'(idx)*PTSIZE +: PTSIZE] <= bus.in_point;
                        idx    <= idx + 8'd1;
                        size_q <= idx + 8'd1;
                        // last beat wins over overflow, so a full 256-point set is not truncated
                        if (bus.in_last) begin
                            state <= ST_HOLD;
                        end else if (idx == 8'(MAXPTS - 1)) begin
                            state   <= ST_DRAIN;
                            trunc_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (transfer && bus.in_last) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.set_ack) begin
                        state    <= ST_FILL;
                        idx      <= 8'd0;
                        points_q <= '0;
                        size_q   <= 8'd0;
                        trunc_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_port_ultra_point_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_m_port_ultra_point_loader
// Brief  : Directed plus randomized checks of the point loader against a slot-list model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_m_port_ultra_point_loader;
    import m_port_ultra_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    bit   ack_noise = 1'b0;

    logic [15:0] mdl_slots[$];
    int          mdl_beats;

    m_port_ultra_point_loader_if bus();

    m_port_ultra_point_loader dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rstn),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [BUSW-1:0] exp_bus();
        logic [BUSW-1:0] b = '0;
        foreach (mdl_slots[i]) b[i*PTSIZE +: PTSIZE] = mdl_slots[i];
        return b;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pts(input string tag, input logic [BUSW-1:0] obs, input logic [BUSW-1:0] exp);
        int          slot = -1;
        logic [15:0] ov = '0;
        logic [15:0] ev = '0;
        for (int i = 0; i < MAXPTS; i++) begin
            if (slot < 0 && obs[i*PTSIZE +: PTSIZE] !== exp[i*PTSIZE +: PTSIZE]) begin
                slot = i;
                ov   = obs[i*PTSIZE +: PTSIZE];
                ev   = exp[i*PTSIZE +: PTSIZE];
            end
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: slot %0d observed %h expected %h", tag, slot, ov, ev);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mdl_slots.delete();
        mdl_beats = 0;
    endtask

    // All stimulus is changed 1 time unit after a rising edge.
    task automatic send_beat(input logic [15:0] p, input logic last);
        int guard = 0;
        bus.in_point = p;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.set_ack  = (ack_noise && !last) ? 1'($urandom) : 1'b0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout: observed in_ready %0b expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.set_ack  = 1'b0;
        mdl_beats++;
        if (mdl_slots.size() < MAXPTS) mdl_slots.push_back(p);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            bus.in_last = 1'($urandom);
            bus.set_ack = ack_noise ? 1'($urandom) : 1'b0;
            tick();
        end
        bus.in_last = 1'b0;
        bus.set_ack = 1'b0;
    endtask

    task automatic check_set(input string tag);
        check_val({tag, "_valid"}, 32'(bus.set_valid), 32'd1);
        check_val({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check_val({tag, "_size"}, 32'(bus.set_size), 32'(8'(mdl_slots.size())));
        check_val({tag, "_trunc"}, 32'(bus.trunc_err), 32'(mdl_beats > MAXPTS));
        check_pts({tag, "_points"}, bus.points, exp_bus());
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, 32'(bus.set_valid), 32'd0);
        check_val({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "_size"}, 32'(bus.set_size), 32'd0);
        check_val({tag, "_trunc"}, 32'(bus.trunc_err), 32'd0);
        check_pts({tag, "_points"}, bus.points, '0);
    endtask

    task automatic do_ack(input string tag);
        bus.set_ack = 1'b1;
        tick();
        bus.set_ack = 1'b0;
        model_clear();
        check_idle(tag);
    endtask

    initial begin
        logic [BUSW-1:0] held;
        logic [63:0]     t1_low;
        int              n;

        rstn         = 1'b0;
        bus.in_point = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.set_ack  = 1'b0;
        model_clear();
        repeat (2) tick();
        rstn = 1'b1;
        check_idle("reset");

        // Test 1: four-point set
        send_beat(16'h0102, 1'b0);
        send_beat(16'h0304, 1'b0);
        send_beat(16'h0506, 1'b0);
        send_beat(16'h0708, 1'b1);
        check_set("t1");
        t1_low = bus.points[63:0];
        check_val("t1_low_lo", t1_low[31:0], 32'h03040102);
        check_val("t1_low_hi", t1_low[63:32], 32'h07080506);

        // Test 2: beats offered in HOLD are refused, then ack and beat in the same cycle
        held = exp_bus();
        bus.in_point = 16'hBEEF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t2_hold_ready", 32'(bus.in_ready), 32'd0);
            check_pts("t2_hold_points", bus.points, held);
        end
        bus.set_ack = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.set_ack  = 1'b0;
        model_clear();
        check_idle("t2_ack");
        tick();
        check_idle("t2_after");

        // Test 3: exactly 256 points
        for (int k = 0; k < 256; k++) send_beat(16'(k), k == 255);
        check_set("t3");
        check_val("t3_slot255", 32'(bus.points[255*PTSIZE +: PTSIZE]), 32'h00FF);
        do_ack("t3_ack");

        // Test 4: 300 points, overflow discarded
        for (int k = 0; k < 300; k++) begin
            send_beat(16'(k), k == 299);
            if (k == 255) begin
                check_val("t4_trunc_early", 32'(bus.trunc_err), 32'd1);
                check_val("t4_valid_early", 32'(bus.set_valid), 32'd0);
            end
        end
        check_set("t4");
        check_val("t4_slot255", 32'(bus.points[255*PTSIZE +: PTSIZE]), 32'h00FF);
        do_ack("t4_ack");

        // Test 5: random sets with gaps and acks during FILL
        ack_noise = 1'b1;
        for (int s = 0; s < 6; s++) begin
            n = (s == 5) ? 258 + int'($urandom_range(0, 6)) : int'($urandom_range(1, 40));
            for (int k = 0; k < n; k++) begin
                gap(int'($urandom_range(0, 3)));
                send_beat(16'($urandom), k == n - 1);
            end
            check_set("t5");
            do_ack("t5_ack");
        end
        ack_noise = 1'b0;

        // Test 6: reset in the middle of a set
        for (int k = 0; k < 10; k++) send_beat(16'($urandom) | 16'h8000, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        model_clear();
        check_idle("t6_reset");
        send_beat(16'h1111, 1'b0);
        send_beat(16'h2222, 1'b0);
        send_beat(16'h3333, 1'b1);
        check_set("t6");
        check_val("t6_size3", 32'(bus.set_size), 32'd3);
        do_ack("t6_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
